// File: rtl/instr_fetch.sv
// Two-state instruction fetch unit: requests a word, holds it in IR for issue, then updates PC.
// Optional retire counter output is enabled with `define INSTR_FETCH_RETIRE_CNT_EN.
module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
`ifdef INSTR_FETCH_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic        valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [0:0] {StFetch, StIssue} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        advance;

`ifdef INSTR_FETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= 32'h0000_0000;
            ir_q    <= 32'h0000_0000;
`ifdef INSTR_FETCH_RETIRE_CNT_EN
            retire_cnt_q <= 32'h0000_0000;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef INSTR_FETCH_RETIRE_CNT_EN
            retire_cnt_q <= retire_cnt_d;
`endif
        end
    end

    // Branch offset already word-aligned by the shift, so pc[1:0] stays 2'b00.
    assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        if (jump) begin
            next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        advance = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!stall) begin
                    advance = 1'b1;
                    pc_d    = next_pc;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

`ifdef INSTR_FETCH_RETIRE_CNT_EN
    assign retire_cnt_d = retire_cnt_q + {31'd0, advance};
    assign retire_cnt   = retire_cnt_q;
`endif

    always_comb begin
        imem_req  = (state_q == StFetch);
        valid     = (state_q == StIssue);
        imem_addr = pc_q;
        pc        = pc_q;
        pc_plus4  = pc_q + 32'd4;
        instr     = ir_q;
        op        = ir_q[31:26];
    end

endmodule
